// File: rtl/sm_rocc_pkg.sv
// ============================================================================
// Module : sm_rocc_pkg
// Brief  : Shared constants for the RoCC command issuer. Holds the custom
//          instruction field positions, the response rd width and the FSM
//          state encodings.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sm_rocc_pkg;

  // Custom instruction field bit positions
  localparam int FUNCT_MSB = 31;
  localparam int FUNCT_LSB = 25;
  localparam int RS2_MSB   = 24;
  localparam int RS2_LSB   = 20;
  localparam int RS1_MSB   = 19;
  localparam int RS1_LSB   = 15;
  localparam int XD_BIT    = 14;
  localparam int XS1_BIT   = 13;
  localparam int XS2_BIT   = 12;
  localparam int RD_MSB    = 11;
  localparam int RD_LSB    = 7;
  localparam int OPC_MSB   = 6;
  localparam int OPC_LSB   = 0;

  localparam int INST_W    = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  // The response rd field sits directly above the data field, so its
  // offset equals the data width chosen by the instantiating module.
  localparam int RESP_RD_W = 5;

  // FSM state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sm_rocc_scoreboard.sv
// ============================================================================
// Module : sm_rocc_scoreboard
// Brief  : Pending-destination-register vector plus in-flight command count.
//          One set port, one clear port, three lookup ports, full flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_rocc_scoreboard
  import sm_rocc_pkg::*;
#(
  parameter int p_max_outst = 4,
  localparam int CNT_W      = $clog2(p_max_outst + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 set_en_i,
  input  logic [REG_IDX_W-1:0] set_idx_i,
  input  logic                 clr_en_i,
  input  logic [REG_IDX_W-1:0] clr_idx_i,
  input  logic                 dec_en_i,
  output logic                 clr_hit_o,
  input  logic [REG_IDX_W-1:0] lk_a_idx_i,
  input  logic [REG_IDX_W-1:0] lk_b_idx_i,
  input  logic [REG_IDX_W-1:0] lk_c_idx_i,
  output logic                 lk_a_hit_o,
  output logic                 lk_b_hit_o,
  output logic                 lk_c_hit_o,
  output logic [CNT_W-1:0]     outst_o,
  output logic                 full_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                w_dec;

  // Lookups read only the registered state (no same-cycle bypass)
  assign lk_a_hit_o = pend_q[lk_a_idx_i];
  assign lk_b_hit_o = pend_q[lk_b_idx_i];
  assign lk_c_hit_o = pend_q[lk_c_idx_i];
  assign clr_hit_o  = pend_q[clr_idx_i];
  assign outst_o    = cnt_q;
  assign full_o     = (cnt_q >= CNT_W'(p_max_outst));

  // Decrement saturates at zero
  assign w_dec = dec_en_i && (cnt_q != '0);

  // Next pending vector and count; clear first so a set on another bit is unaffected
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_idx_i] = 1'b0;
    if (set_en_i) pend_d[set_idx_i] = 1'b1;
    cnt_d = cnt_q;
    case ({set_en_i, w_dec})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Scoreboard state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sm_rocc_cmd_issuer.sv
// ============================================================================
// Module : sm_rocc_cmd_issuer
// Brief  : RoCC initiator. Packs a custom instruction with its operands into
//          a command, tracks outstanding rd writes and stalls hazards, and
//          turns accelerator responses into a one-cycle writeback pulse.
//          Optional build macro: SM_ROCC_ISSUER_ERRCHK_EN (protocol error
//          detection on unexpected responses and stray cmd_rdy).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_rocc_cmd_issuer
  import sm_rocc_pkg::*;
#(
  parameter int p_rs1bits      = 32,
  parameter int p_rd_data_bits = 32,
  parameter int p_max_outst    = 4,
  localparam int OUTST_W       = $clog2(p_max_outst + 1),
  localparam int MSG_W         = 2 * p_rs1bits + INST_W,
  localparam int RESP_W        = RESP_RD_W + p_rd_data_bits
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_val,
  output logic                      req_rdy,
  input  logic [INST_W-1:0]         req_inst,
  input  logic [p_rs1bits-1:0]      req_rs1,
  input  logic [p_rs1bits-1:0]      req_rs2,
  output logic [MSG_W-1:0]          cmd_msg,
  output logic                      cmd_val,
  input  logic                      cmd_rdy,
  input  logic [RESP_W-1:0]         resp_msg,
  input  logic                      resp_val,
  output logic                      resp_rdy,
  output logic                      wb_val,
  output logic [4:0]                wb_rd,
  output logic [p_rd_data_bits-1:0] wb_data,
  output logic [OUTST_W-1:0]        outst,
  output logic                      err
);

  logic [0:0]                state_q, state_d;
  logic [MSG_W-1:0]          cmd_msg_q, cmd_msg_d;
  logic                      wb_val_q;
  logic [4:0]                wb_rd_q;
  logic [p_rd_data_bits-1:0] wb_data_q;

  logic                      w_xd, w_xs1, w_xs2;
  logic [REG_IDX_W-1:0]      w_rd, w_rs1_idx, w_rs2_idx;
  logic                      w_hit_rd, w_hit_rs1, w_hit_rs2;
  logic                      w_hazard, w_full, w_accept;
  logic                      w_resp_fire, w_dec_en;
  logic [REG_IDX_W-1:0]      w_resp_rd;
  logic [p_rd_data_bits-1:0] w_resp_data;

  // Instruction field decode
  assign w_xd      = req_inst[XD_BIT];
  assign w_xs1     = req_inst[XS1_BIT];
  assign w_xs2     = req_inst[XS2_BIT];
  assign w_rd      = req_inst[RD_MSB:RD_LSB];
  assign w_rs1_idx = req_inst[RS1_MSB:RS1_LSB];
  assign w_rs2_idx = req_inst[RS2_MSB:RS2_LSB];

  // Response unpack and handshake; responses are accepted whenever out of reset
  assign w_resp_rd   = resp_msg[RESP_W-1:p_rd_data_bits];
  assign w_resp_data = resp_msg[p_rd_data_bits-1:0];
  assign resp_rdy    = reset_n;
  assign w_resp_fire = resp_val && resp_rdy;

  assign w_hazard = (w_xd & w_hit_rd) | (w_xs1 & w_hit_rs1) | (w_xs2 & w_hit_rs2);

  assign cmd_val = (state_q == ST_SEND);
  assign cmd_msg = cmd_msg_q;
  assign wb_val  = wb_val_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

`ifdef SM_ROCC_ISSUER_ERRCHK_EN
  logic w_clr_hit;
  logic err_q, err_d;

  // Unexpected responses are written back but do not retire a command
  assign w_dec_en = w_resp_fire && w_clr_hit;

  // Sticky error on unexpected rd or cmd_rdy outside SEND
  always_comb begin
    err_d = err_q | (w_resp_fire & ~w_clr_hit) | (cmd_rdy & ~cmd_val);
  end

  // Error flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`else
  assign w_dec_en = w_resp_fire;
  assign err      = 1'b0;
`endif

  sm_rocc_scoreboard #(
    .p_max_outst (p_max_outst)
  ) u_sb (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_en_i   (w_accept && w_xd),
    .set_idx_i  (w_rd),
    .clr_en_i   (w_resp_fire),
    .clr_idx_i  (w_resp_rd),
    .dec_en_i   (w_dec_en),
`ifdef SM_ROCC_ISSUER_ERRCHK_EN
    .clr_hit_o  (w_clr_hit),
`else
    .clr_hit_o  (),
`endif
    .lk_a_idx_i (w_rd),
    .lk_b_idx_i (w_rs1_idx),
    .lk_c_idx_i (w_rs2_idx),
    .lk_a_hit_o (w_hit_rd),
    .lk_b_hit_o (w_hit_rs1),
    .lk_c_hit_o (w_hit_rs2),
    .outst_o    (outst),
    .full_o     (w_full)
  );

  // Issue FSM: accept in IDLE, hold the command in SEND until taken
  always_comb begin
    state_d   = state_q;
    cmd_msg_d = cmd_msg_q;
    req_rdy   = 1'b0;
    w_accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_rdy = ~w_hazard & (~w_xd | ~w_full);
        if (req_val && req_rdy) begin
          w_accept  = 1'b1;
          cmd_msg_d = {req_rs2, req_rs1, req_inst};
          state_d   = ST_SEND;
        end
      end
      default: begin
        if (cmd_rdy) state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and command registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cmd_msg_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_msg_q <= cmd_msg_d;
    end
  end

  // Writeback pulse; rd/data hold between pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_val_q  <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      wb_val_q <= w_resp_fire;
      if (w_resp_fire) begin
        wb_rd_q   <= w_resp_rd;
        wb_data_q <= w_resp_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sm_rocc_cmd_issuer.sv
// ============================================================================
// Module : tb_sm_rocc_cmd_issuer
// Brief  : Directed self-checking bench for sm_rocc_cmd_issuer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm_rocc_cmd_issuer;

  logic        clk;
  logic        reset_n;
  logic        req_val;
  logic        req_rdy;
  logic [31:0] req_inst;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [95:0] cmd_msg;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [36:0] resp_msg;
  logic        resp_val;
  logic        resp_rdy;
  logic        wb_val;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  outst;
  logic        err;

  int checks   = 0;
  int failures = 0;
  logic        exp_err;
  logic [95:0] held_msg;

  sm_rocc_cmd_issuer #(
    .p_rs1bits      (32),
    .p_rd_data_bits (32),
    .p_max_outst    (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_inst (req_inst),
    .req_rs1  (req_rs1),
    .req_rs2  (req_rs2),
    .cmd_msg  (cmd_msg),
    .cmd_val  (cmd_val),
    .cmd_rdy  (cmd_rdy),
    .resp_msg (resp_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .wb_val   (wb_val),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .outst    (outst),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; registered effects are visible at the next negedge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input logic xd, input logic xs1, input logic xs2,
                                     input logic [4:0] rd, input logic [4:0] rs1i,
                                     input logic [4:0] rs2i);
    return {7'h00, rs2i, rs1i, xd, xs1, xs2, rd, 7'h0B};
  endfunction

  task automatic finish_cmd();
    req_val = 1'b0;
    cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
  endtask

  initial begin
`ifdef SM_ROCC_ISSUER_ERRCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset_n  = 1'b0;
    req_val  = 1'b0;
    req_inst = '0;
    req_rs1  = '0;
    req_rs2  = '0;
    cmd_rdy  = 1'b0;
    resp_msg = '0;
    resp_val = 1'b0;
    @(negedge clk);
    tick();

    // Reset state
    chk("rst_resp_rdy", resp_rdy, 1'b0);
    chk("rst_cmd_val", cmd_val, 1'b0);
    chk("rst_cmd_msg", cmd_msg, 96'h0);
    chk("rst_outst", outst, 3'd0);
    chk("rst_wb_val", wb_val, 1'b0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_err", err, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("idle_resp_rdy", resp_rdy, 1'b1);
    chk("idle_req_rdy", req_rdy, 1'b1);

    // Non-xd command
    @(negedge clk);
    req_val  = 1'b1;
    req_inst = 32'h0000_200B;
    req_rs1  = 32'h5;
    req_rs2  = 32'h0;
    #1;
    chk("t1_req_rdy", req_rdy, 1'b1);
    tick();
    req_val = 1'b0;
    #1;
    chk("t1_cmd_val", cmd_val, 1'b1);
    chk("t1_cmd_msg", cmd_msg, {32'h0, 32'h5, 32'h0000_200B});
    chk("t1_outst", outst, 3'd0);
    chk("t1_send_req_rdy", req_rdy, 1'b0);
    finish_cmd();
    chk("t1_cmd_val_drop", cmd_val, 1'b0);

    // Backpressure, xd rd=3; request held high across SEND
    req_val  = 1'b1;
    req_inst = mk(1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0);
    req_rs1  = 32'h11;
    req_rs2  = 32'h22;
    tick();
    held_msg = {32'h22, 32'h11, 32'h0000_418B};
    chk("t2_outst", outst, 3'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_cmd_val", cmd_val, 1'b1);
      chk("t2_cmd_msg", cmd_msg, held_msg);
      chk("t2_req_rdy", req_rdy, 1'b0);
      tick();
    end
    cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    #1;
    chk("t2_cmd_val_drop", cmd_val, 1'b0);
    chk("t2_rd_hazard", req_rdy, 1'b0);
    chk("t2_outst_hold", outst, 3'd1);
    req_val = 1'b0;

    // RAW stall on rs1 index 3
    @(negedge clk);
    req_val  = 1'b1;
    req_inst = mk(1'b0, 1'b1, 1'b0, 5'd0, 5'd3, 5'd0);
    req_rs1  = 32'h77;
    req_rs2  = 32'h0;
    #1;
    chk("t3_stall", req_rdy, 1'b0);
    tick();
    resp_val = 1'b1;
    resp_msg = {5'd3, 32'h0000_DEAD};
    #1;
    chk("t3_no_bypass", req_rdy, 1'b0);
    tick();
    resp_val = 1'b0;
    #1;
    chk("t3_wb_val", wb_val, 1'b1);
    chk("t3_wb_rd", wb_rd, 5'd3);
    chk("t3_wb_data", wb_data, 32'h0000_DEAD);
    chk("t3_outst", outst, 3'd0);
    chk("t3_req_rdy", req_rdy, 1'b1);
    chk("t3_err", err, 1'b0);
    tick();
    chk("t3_wb_pulse_end", wb_val, 1'b0);
    chk("t3_wb_rd_hold", wb_rd, 5'd3);
    chk("t3_cmd_val", cmd_val, 1'b1);
    chk("t3_cmd_msg", cmd_msg, {32'h0, 32'h77, 32'h0001_A00B});
    finish_cmd();

    // Cap: four xd commands to rd 1..4
    for (int i = 1; i <= 4; i++) begin
      req_val  = 1'b1;
      req_inst = mk(1'b1, 1'b0, 1'b0, 5'(i), 5'd0, 5'd0);
      tick();
      finish_cmd();
    end
    chk("t4_outst_full", outst, 3'd4);
    req_inst = mk(1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0);
    #1;
    chk("t4_cap_stall", req_rdy, 1'b0);
    @(negedge clk);
    req_val  = 1'b1;
    req_inst = 32'h0000_000B;
    #1;
    chk("t4_nonxd_ok", req_rdy, 1'b1);
    tick();
    chk("t4_nonxd_cmd_val", cmd_val, 1'b1);
    chk("t4_outst_unch", outst, 3'd4);
    finish_cmd();

    // Retire rd 4 and 3 to reach outst=2
    resp_val = 1'b1;
    resp_msg = {5'd4, 32'h4};
    tick();
    resp_msg = {5'd3, 32'h3};
    tick();
    resp_val = 1'b0;
    chk("t5_outst2", outst, 3'd2);

    // Same-cycle xd accept (rd=7) and response (rd=1)
    req_val  = 1'b1;
    req_inst = mk(1'b1, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0);
    resp_val = 1'b1;
    resp_msg = {5'd1, 32'h1111};
    #1;
    chk("t5_req_rdy", req_rdy, 1'b1);
    tick();
    resp_val = 1'b0;
    req_val  = 1'b0;
    #1;
    chk("t5_outst_same", outst, 3'd2);
    chk("t5_wb_rd", wb_rd, 5'd1);
    chk("t5_cmd_val", cmd_val, 1'b1);
    finish_cmd();
    req_inst = mk(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7);
    #1;
    chk("t5_sb7_set", req_rdy, 1'b0);
    req_inst = mk(1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd0);
    #1;
    chk("t5_sb1_clr", req_rdy, 1'b1);

    // Drain rd 2 and 7
    @(negedge clk);
    resp_val = 1'b1;
    resp_msg = {5'd2, 32'h2};
    tick();
    resp_msg = {5'd7, 32'h7};
    tick();
    resp_val = 1'b0;
    chk("t5_drained", outst, 3'd0);
    chk("t5_err_clean", err, 1'b0);

    // Unexpected response rd=9
    resp_val = 1'b1;
    resp_msg = {5'd9, 32'h1234};
    tick();
    resp_val = 1'b0;
    #1;
    chk("t6_wb_val", wb_val, 1'b1);
    chk("t6_wb_rd", wb_rd, 5'd9);
    chk("t6_wb_data", wb_data, 32'h1234);
    chk("t6_outst", outst, 3'd0);
    chk("t6_err", err, exp_err);
    tick();
    tick();
    chk("t6_err_sticky", err, exp_err);

    // Reset while in SEND drops the command and clears tracking
    req_val  = 1'b1;
    req_inst = mk(1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0);
    tick();
    req_val = 1'b0;
    chk("t7_cmd_val", cmd_val, 1'b1);
    chk("t7_outst", outst, 3'd1);
    reset_n = 1'b0;
    #1;
    chk("t7_rst_cmd_val", cmd_val, 1'b0);
    chk("t7_rst_outst", outst, 3'd0);
    chk("t7_rst_err", err, 1'b0);
    chk("t7_rst_resp_rdy", resp_rdy, 1'b0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("t7_sb_cleared", req_rdy, 1'b1);
    tick();
    chk("t7_idle_cmd_val", cmd_val, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sm_rocc_cmd_issuer.md
Name: sm_rocc_cmd_issuer

Overview:
- Initiator side of the RoCC command/response interface; sits on the core side facing an accelerator.
- Packs a decoded custom instruction plus rs1/rs2 operands into a command message and sends it over a val/rdy channel.
- Tracks outstanding destination registers in a scoreboard and stalls hazardous requests.
- Unpacks accelerator responses ({rd,data}) into a one-cycle register writeback pulse.

Parameters:
- p_rs1bits, 32, width of each source operand field in the command message
- p_rd_data_bits, 32, width of response data
- p_max_outst, 4, maximum in-flight xd=1 commands (1..31)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_val  in  1  instruction request valid
- req_rdy  out  1  issuer accepts request
- req_inst  in  32  raw custom instruction: funct[31:25] rs2[24:20] rs1[19:15] xd[14] xs1[13] xs2[12] rd[11:7] opcode[6:0]
- req_rs1  in  p_rs1bits  rs1 operand value
- req_rs2  in  p_rs1bits  rs2 operand value
- cmd_msg  out  2*p_rs1bits+32  packed command {rs2, rs1, inst[31:0]}
- cmd_val  out  1  command valid
- cmd_rdy  in  1  accelerator accepts command
- resp_msg  in  5+p_rd_data_bits  packed response {rd[4:0], data}
- resp_val  in  1  response valid
- resp_rdy  out  1  issuer accepts response
- wb_val  out  1  writeback pulse
- wb_rd  out  5  writeback register index
- wb_data  out  p_rd_data_bits  writeback data
- outst  out  $clog2(p_max_outst+1)  in-flight xd command count
- err  out  1  sticky protocol error

Behaviour:
- Reset (async assert, sync release): state=IDLE, cmd_val=0, cmd_msg=0, scoreboard=0, outst=0, wb_val=0, wb_rd=0, wb_data=0, err=0. resp_rdy=0 while reset_n=0, else 1.
- FSM IDLE:
  - req_rdy=1 iff no hazard and (xd=0 or outst<p_max_outst).
  - Hazard: (xd & sb[rd]) | (xs1 & sb[rs1idx]) | (xs2 & sb[rs2idx]).
  - Hazard and cap checks use the registered scoreboard/count; there is no bypass of a same-cycle response clear.
  - x0 is tracked like any other index.
  - On req_val & req_rdy: latch {req_rs2, req_rs1, req_inst} into cmd_msg; if xd, set sb[rd] and increment outst; go to SEND.
- FSM SEND:
  - req_rdy=0, cmd_val=1, cmd_msg held stable until cmd_rdy.
  - On cmd_rdy: cmd_val=0 next cycle, go to IDLE.
  - Latency: request accepted cycle N -> cmd_val at N+1. Peak throughput is 1 command per 2 cycles.
- Response path:
  - On resp_val & resp_rdy: clear sb[resp rd], decrement outst (saturating at 0).
  - Next cycle: wb_val=1, wb_rd=rd, wb_data=data, for one cycle only.
  - wb_rd/wb_data hold their last value when wb_val=0.
- Simultaneous xd-accept and response fire: set and clear act on their own bits; outst is unchanged (+1-1).
- cmd_rdy asserted while in IDLE is ignored.
- Reset mid-SEND drops the command; scoreboard and count are cleared.

Optional Feature:
- Macro SM_ROCC_ISSUER_ERRCHK_EN.
- Defined: err sets (sticky until reset) on either of:
  - a response whose rd has sb[rd]=0;
  - cmd_rdy sampled when cmd_val=0.
- Defined: a response with an unexpected rd is still written back, but outst is not decremented.
- Undefined: err tied 0; every response decrements outst (saturating).

Decomposition:
- Package sm_rocc_pkg:
  - instruction field bit positions (funct/rs2/rs1/xd/xs1/xs2/rd/opcode);
  - response rd offset;
  - FSM state enum {IDLE, SEND}.
- One sub-module, sm_rocc_scoreboard:
  - 32-bit pending-rd vector plus outst counter;
  - set port, clear port, three lookup ports, and a full flag.

Test Plan:
- Non-xd command: req_inst=0x0000_200B (xs1=1, xd=0), rs1=0x5 -> cmd_val at N+1, cmd_msg={0,5,0x0000200B}; outst stays 0.
- Backpressure: xd command rd=3, cmd_rdy low for 5 cycles -> cmd_msg stable, req_rdy=0 throughout; sb[3]=1, outst=1.
- RAW stall: rd=3 pending, new req with xs1=1 and rs1idx=3 -> req_rdy=0; resp {3,0xDEAD} arrives -> wb_val pulse with rd=3, data=0xDEAD next cycle; req accepted the cycle after.
- Cap: 4 xd commands to rd 1..4 with no responses -> 5th xd req stalls (outst=4); a non-xd req is still accepted.
- Same-cycle accept plus response: outst=2, accept xd rd=7 while resp rd=1 fires -> outst stays 2, sb[7]=1, sb[1]=0.
- ERRCHK: resp rd=9 with sb[9]=0 -> err=1 and held until reset_n low; wb_val still pulses with rd=9.
